alu_acc_seq: RTL and testbench
==============================

Name: alu_acc_seq

Overview:
- Parametrised accumulator ALU. The accumulator's low WIDTH bits are fed back as operand B. Opcodes are executed on a Start pulse.
- Single-cycle logic/arithmetic ops plus a multi-cycle shift-add multiply, with a Start/Busy/Done handshake.
- Sits between board I/O (switches/keys) and display logic. HEX/LED drivers stay in the top-level wrapper.

Parameters:
- WIDTH, 4, operand A width and feedback-operand B width (B = Acc[WIDTH-1:0]); legal range 2..16.
- ACC_W, 2*WIDTH, accumulator/result width; must be >= WIDTH+1.

Ports:
- Clock  input  1  rising-edge clock.
- Restn  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A.
- Func  input  3  opcode, sampled with Start.
- Start  input  1  request; sampled on rising edge; ignored while Busy=1.
- Acc  output  ACC_W  accumulator register (result).
- Busy  output  1  high while a multiply is in progress.
- Done  output  1  one-cycle pulse after Acc is written.
- Carry  output  1  registered carry/borrow flag.
- Zero  output  1  combinational, equals (Acc == 0).

Behaviour:
- Reset (Restn=0, async, any state):
  - Acc=0, Carry=0, Busy=0, Done=0, state=IDLE.
  - Any multiply in progress is aborted with no partial write.
- B = Acc[WIDTH-1:0]. All results are zero-extended to ACC_W.
- Opcodes:
  - 000 ADD: A+B, (WIDTH+1)-bit result; Carry = bit WIDTH.
  - 001 SUB: A-B modulo 2^ACC_W; Carry = borrow (A<B).
  - 010 NANDNOR: {~(A&B), ~(A|B)}.
  - 011 ANY: if (A|B) != 0, Acc = 2'b11 in the top two bits, else 0.
  - 100 CAT: {B, ~A}.
  - 101 XOR: {A^B, A~^B}.
  - 110 MUL: A*B, sequential (see below).
  - 111 HOLD: Acc unchanged.
  - Opcodes 010..111 clear Carry when written, except HOLD, which also keeps Carry.
  - For 2*WIDTH-wide results, the concatenation occupies Acc[2*WIDTH-1:0].
- FSM states:
  - IDLE:
    - Start=1 with Func != 110: Acc and Carry are written on that edge. Done=1 for the following cycle. Stay in IDLE.
    - Start=1 with Func=110: latch mcand=A and mplier=B, clear the product and the counter, go to MUL. Busy=1 from the next cycle.
  - MUL: one iteration per edge.
    - If mplier[0]=1: product += mcand << cnt.
    - Then mplier >>= 1 and cnt++.
    - On the edge where cnt reaches WIDTH-1: Acc=product, Carry=0, go to IDLE, Done=1 for one cycle, Busy=0.
- Timing:
  - Busy is high for exactly WIDTH cycles.
  - Acc is updated WIDTH edges after the Start edge.
  - Back-to-back Start is allowed: Start may be high in the same cycle Done is high, and it is accepted.
- Start during Busy is dropped, with no queuing.
- Func and A changes during MUL have no effect, because the operands are latched.
- Done and Busy are never high together.

Optional Feature:
- Macro: ALU_ACC_SAT_EN.
- Defined:
  - SUB with A<B writes Acc=0 (saturate) and sets Carry=1.
  - ADD is unchanged.
- Undefined: SUB wraps modulo 2^ACC_W, as above.

Decomposition:
- Package alu_acc_pkg holds:
  - Opcode localparams (FN_ADD..FN_HOLD).
  - FSM state encoding (ST_IDLE, ST_MUL).
  - Default WIDTH.
- Sub-module alu_acc_seq_mul: holds the mcand/mplier/product/cnt datapath, with start/busy/done ports. The top FSM instantiates it and muxes its product into Acc.

Test Plan (WIDTH=4, ACC_W=8):
- Assert Restn=0 mid-run, asynchronously -> Acc=0x00, Zero=1, Busy=0, Done=0 before the next clock edge.
- From reset, ADD A=5 -> Acc=0x05, Done pulses once; then ADD A=0xF -> Acc=0x14, Carry=1.
- Acc=0x14 (B=4), MUL A=0xD:
  - Busy high for 4 cycles, then Acc=0x34 and Done=1 for 1 cycle.
  - A toggled during Busy has no effect.
  - A Start with Func=000 pulsed during Busy is ignored.
- Acc=0x34 (B=4), SUB A=2 -> Acc=0xFE, Carry=1; with ALU_ACC_SAT_EN -> Acc=0x00, Carry=1, Zero=1.
- Acc=0x00, ANY A=0 -> Acc=0x00; ANY A=1 -> Acc=0xC0.
- B=0, CAT A=0x3 -> Acc=0x0C; then XOR A=0xF (B=0xC) -> Acc=0x3C; HOLD -> Acc stays 0x3C, Done pulses.

Source files
------------

// File: rtl/alu_acc_pkg.sv
// Shared opcodes, FSM encoding and default operand width for the accumulator ALU.
package alu_acc_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [2:0] FN_ADD     = 3'b000;
  localparam logic [2:0] FN_SUB     = 3'b001;
  localparam logic [2:0] FN_NANDNOR = 3'b010;
  localparam logic [2:0] FN_ANY     = 3'b011;
  localparam logic [2:0] FN_CAT     = 3'b100;
  localparam logic [2:0] FN_XOR     = 3'b101;
  localparam logic [2:0] FN_MUL     = 3'b110;
  localparam logic [2:0] FN_HOLD    = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_acc_seq_mul.sv
// Shift-add multiplier datapath: one partial product per cycle while busy_i is high.
// done_o flags the final iteration; product_o already includes that iteration's add.
module alu_acc_seq_mul
  import alu_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 busy_i,
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [WIDTH-1:0]     mplier_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] product_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] addend;

  always_comb begin
    addend    = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
    product_o = product_q + addend;
    done_o    = busy_i && (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else if (start_i) begin
      mcand_q   <= mcand_i;
      mplier_q  <= mplier_i;
      product_q <= '0;
      cnt_q     <= '0;
    end else if (busy_i) begin
      product_q <= product_o;
      mplier_q  <= mplier_q >> 1;
      cnt_q     <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator ALU with Start/Busy/Done handshake; operand B is fed back from Acc[WIDTH-1:0].
// Define ALU_ACC_SAT_EN to make SUB saturate at zero on borrow instead of wrapping.
module alu_acc_seq
  import alu_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = 2 * WIDTH
) (
  input  logic             Clock,
  input  logic             Restn,
  input  logic [WIDTH-1:0] A,
  input  logic [2:0]       Func,
  input  logic             Start,
  output logic [ACC_W-1:0] Acc,
  output logic             Busy,
  output logic             Done,
  output logic             Carry,
  output logic             Zero
);

  // Results are formed at least 2*WIDTH wide so concatenations never lose bits before resizing.
  localparam int RW = (ACC_W > 2 * WIDTH) ? ACC_W : 2 * WIDTH;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   b;
  logic [RW-1:0]      res;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [RW-1:0]      mul_ext;

  assign b       = acc_q[WIDTH-1:0];
  assign mul_ext = RW'(mul_product);

  alu_acc_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (Clock),
    .rst_n     (Restn),
    .start_i   (mul_start),
    .busy_i    (state_q == ST_MUL),
    .mcand_i   (A),
    .mplier_i  (b),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    done_d    = 1'b0;
    mul_start = 1'b0;
    res       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (Func == FN_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            done_d  = 1'b1;
            carry_d = 1'b0;
            case (Func)
              FN_ADD: begin
                res     = RW'(A) + RW'(b);
                carry_d = res[WIDTH];
              end
              FN_SUB: begin
                res     = RW'(A) - RW'(b);
                carry_d = (A < b);
`ifdef ALU_ACC_SAT_EN
                if (A < b) res = '0;
`endif
              end
              FN_NANDNOR: res = RW'({~(A & b), ~(A | b)});
              FN_ANY: begin
                if ((A | b) != '0) res[ACC_W-1 -: 2] = 2'b11;
              end
              FN_CAT: res = RW'({b, ~A});
              FN_XOR: res = RW'({A ^ b, A ~^ b});
              default: begin
                res     = RW'(acc_q);
                carry_d = carry_q;
              end
            endcase
            acc_d = res[ACC_W-1:0];
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          acc_d   = mul_ext[ACC_W-1:0];
          carry_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Restn) begin
    if (!Restn) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of the others.
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign Acc   = acc_q;
  assign Busy  = (state_q == ST_MUL);
  assign Done  = done_q;
  assign Carry = carry_q;
  assign Zero  = (acc_q == '0);

endmodule

// File: tb/tb_alu_acc_seq.sv
// Self-checking bench for alu_acc_seq (WIDTH=4, ACC_W=8) against an arithmetic reference model.
module tb_alu_acc_seq;

  localparam int W  = 4;
  localparam int AW = 8;
  localparam int M  = 1 << W;
  localparam int AM = 1 << AW;

  logic          Clock;
  logic          Restn;
  logic [W-1:0]  A;
  logic [2:0]    Func;
  logic          Start;
  logic [AW-1:0] Acc;
  logic          Busy;
  logic          Done;
  logic          Carry;
  logic          Zero;

  int checks = 0;
  int errors = 0;
  int m_acc  = 0;
  int m_carry = 0;

  alu_acc_seq #(.WIDTH(W), .ACC_W(AW)) dut (
    .Clock (Clock),
    .Restn (Restn),
    .A     (A),
    .Func  (Func),
    .Start (Start),
    .Acc   (Acc),
    .Busy  (Busy),
    .Done  (Done),
    .Carry (Carry),
    .Zero  (Zero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: each opcode's effect on (acc, carry), from the operand values alone.
  function automatic void model_apply(input int f, input int a);
    int bb;
    int x;
    bb = m_acc % M;
    x  = a ^ bb;
    if (f >= 2 && f <= 6) m_carry = 0;
    case (f)
      0: begin
        m_acc   = a + bb;
        m_carry = (a + bb >= M) ? 1 : 0;
      end
      1: begin
        m_carry = (a < bb) ? 1 : 0;
        if (a >= bb) m_acc = a - bb;
        else begin
`ifdef ALU_ACC_SAT_EN
          m_acc = 0;
`else
          m_acc = a - bb + AM;
`endif
        end
      end
      2: m_acc = ((M - 1) - (a & bb)) * M + ((M - 1) - (a | bb));
      3: m_acc = ((a | bb) != 0) ? 3 * (AM / 4) : 0;
      4: m_acc = bb * M + (M - 1 - a);
      5: m_acc = x * M + (M - 1 - x);
      6: m_acc = (a * bb) % AM;
      default: ;
    endcase
  endfunction

  // Issue one opcode and check the completion cycle against the model.
  task automatic exec_op(input int f, input int a, input bit b2b, input bit toggle, input bit poke);
    int busy_cnt;
    if (!b2b) begin
      @(negedge Clock);
      checks++;
      if (Done !== 1'b0) begin
        errors++;
        $display("FAIL done_single_cycle: Done=%0b required 0", Done);
      end
    end
    Start = 1'b1;
    Func  = f[2:0];
    A     = a[W-1:0];
    model_apply(f, a);
    @(negedge Clock);
    Start = 1'b0;
    if (f == 6) begin
      busy_cnt = 0;
      while (Busy === 1'b1 && busy_cnt < 40) begin
        checks++;
        if (Done !== 1'b0) begin
          errors++;
          $display("FAIL done_during_busy: Done=%0b required 0", Done);
        end
        busy_cnt++;
        if (toggle) A = W'($urandom_range(0, M - 1));
        if (poke && busy_cnt == 2) begin
          Start = 1'b1;
          Func  = 3'b000;
        end else begin
          Start = 1'b0;
        end
        @(negedge Clock);
      end
      Start = 1'b0;
      checks++;
      if (busy_cnt != W) begin
        errors++;
        $display("FAIL mul_busy_cycles: got %0d required %0d", busy_cnt, W);
      end
    end
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse func=%0d: Done=%0b required 1", f, Done);
    end
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done func=%0d: Busy=%0b required 0", f, Busy);
    end
    checks++;
    if (Acc !== AW'(m_acc)) begin
      errors++;
      $display("FAIL acc func=%0d a=%0h: Acc=%0h required %0h", f, a, Acc, m_acc);
    end
    checks++;
    if (Carry !== m_carry[0]) begin
      errors++;
      $display("FAIL carry func=%0d a=%0h: Carry=%0b required %0b", f, a, Carry, m_carry[0]);
    end
    checks++;
    if (Zero !== (m_acc == 0)) begin
      errors++;
      $display("FAIL zero func=%0d: Zero=%0b required %0b", f, Zero, (m_acc == 0));
    end
  endtask

  task automatic test_reset();
    Restn = 1'b0;
    Start = 1'b0;
    Func  = 3'b000;
    A     = '0;
    repeat (3) @(negedge Clock);
    checks++;
    if (Acc !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0 || Carry !== 1'b0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: Acc=%0h Busy=%0b Done=%0b Carry=%0b Zero=%0b required 0 0 0 0 1",
               Acc, Busy, Done, Carry, Zero);
    end
    Restn = 1'b1;
    m_acc = 0;
    m_carry = 0;
  endtask

  task automatic test_add();
    exec_op(0, 5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Acc !== 8'h05) begin
      errors++;
      $display("FAIL add_5: Acc=%0h required 05", Acc);
    end
    exec_op(0, 15, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Acc !== 8'h14 || Carry !== 1'b1) begin
      errors++;
      $display("FAIL add_f: Acc=%0h Carry=%0b required 14 1", Acc, Carry);
    end
  endtask

  task automatic test_mul();
    exec_op(6, 13, 1'b0, 1'b1, 1'b1);
    checks++;
    if (Acc !== 8'h34 || Carry !== 1'b0) begin
      errors++;
      $display("FAIL mul_d_by_4: Acc=%0h Carry=%0b required 34 0", Acc, Carry);
    end
  endtask

  task automatic test_sub();
    exec_op(1, 2, 1'b0, 1'b0, 1'b0);
    checks++;
`ifdef ALU_ACC_SAT_EN
    if (Acc !== 8'h00 || Carry !== 1'b1 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL sub_borrow_sat: Acc=%0h Carry=%0b Zero=%0b required 00 1 1", Acc, Carry, Zero);
    end
`else
    if (Acc !== 8'hFE || Carry !== 1'b1) begin
      errors++;
      $display("FAIL sub_borrow: Acc=%0h Carry=%0b required fe 1", Acc, Carry);
    end
`endif
  endtask

  task automatic test_any();
    int low;
    low = m_acc % M;
    if (m_acc != 0) exec_op(1, low, 1'b0, 1'b0, 1'b0);
    exec_op(3, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Acc !== 8'h00) begin
      errors++;
      $display("FAIL any_zero: Acc=%0h required 00", Acc);
    end
    exec_op(3, 1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Acc !== 8'hC0) begin
      errors++;
      $display("FAIL any_one: Acc=%0h required c0", Acc);
    end
  endtask

  task automatic test_cat_xor_hold();
    exec_op(4, 3, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Acc !== 8'h0C) begin
      errors++;
      $display("FAIL cat: Acc=%0h required 0c", Acc);
    end
    exec_op(5, 15, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Acc !== 8'h3C) begin
      errors++;
      $display("FAIL xor: Acc=%0h required 3c", Acc);
    end
    exec_op(7, 9, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Acc !== 8'h3C) begin
      errors++;
      $display("FAIL hold: Acc=%0h required 3c", Acc);
    end
  endtask

  task automatic test_back_to_back();
    exec_op(0, 3, 1'b0, 1'b0, 1'b0);
    exec_op(6, 5, 1'b1, 1'b0, 1'b0);
    exec_op(6, 7, 1'b1, 1'b1, 1'b0);
    exec_op(5, 10, 1'b1, 1'b0, 1'b0);
    exec_op(2, 6, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int f;
    int a;
    for (int i = 0; i < 150; i++) begin
      f = $urandom_range(0, 7);
      a = $urandom_range(0, M - 1);
      exec_op(f, a, ($urandom_range(0, 3) == 0), (f == 6), (f == 6) && ($urandom_range(0, 1) == 1));
    end
  endtask

  task automatic test_async_reset();
    exec_op(0, 5, 1'b0, 1'b0, 1'b0);
    @(negedge Clock);
    Start = 1'b1;
    Func  = 3'b110;
    A     = 4'h7;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    #2;
    Restn = 1'b0;
    #1;
    checks++;
    if (Acc !== 8'h00 || Zero !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0 || Carry !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: Acc=%0h Zero=%0b Busy=%0b Done=%0b Carry=%0b required 00 1 0 0 0",
               Acc, Zero, Busy, Done, Carry);
    end
    @(negedge Clock);
    Restn = 1'b1;
    m_acc = 0;
    m_carry = 0;
    repeat (W + 1) @(negedge Clock);
    checks++;
    if (Acc !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_write: Acc=%0h Busy=%0b Done=%0b required 00 0 0", Acc, Busy, Done);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_sub();
    test_any();
    test_cat_xor_hold();
    test_back_to_back();
    test_random();
    test_async_reset();
    exec_op(0, 9, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
